// File: rtl/inst_encoder_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_encoder_loader_pkg : tuple kinds, MIPS opcodes and FSM states
// Revision: 1.0
// ---------------------------------------------------------------------------
package inst_encoder_loader_pkg;

  localparam int WORD = 32;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_BEQ  = 3'd1,
    KIND_BNE  = 3'd2,
    KIND_ADDI = 3'd3,
    KIND_LW   = 3'd4,
    KIND_SW   = 3'd5,
    KIND_J    = 3'd6,
    KIND_ILL  = 3'd7
  } kind_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [WORD-1:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encoder_loader_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_pack : combinational field-tuple to 32-bit MIPS word encoder
// Revision: 1.0
// ---------------------------------------------------------------------------
module inst_pack
  import inst_encoder_loader_pkg::*;
(
  input  logic [2:0]      kind,
  input  logic [4:0]      rs,
  input  logic [4:0]      rt,
  input  logic [4:0]      rd,
  input  logic [5:0]      func,
  input  logic [15:0]     imm,
  input  logic [25:0]     target,
  output logic [WORD-1:0] word,
  output logic            illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind_e'(kind))
      KIND_R:    word = {OP_R, rs, rt, rd, 5'b0, func};
      KIND_BEQ:  word = i_type(OP_BEQ, rs, rt, imm);
      KIND_BNE:  word = i_type(OP_BNE, rs, rt, imm);
      KIND_ADDI: word = i_type(OP_ADDI, rs, rt, imm);
      KIND_LW:   word = i_type(OP_LW, rs, rt, imm);
      KIND_SW:   word = i_type(OP_SW, rs, rt, imm);
      KIND_J:    word = {OP_J, target};
      default:   illegal = 1'b1; // encodes as a nop
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inst_encoder_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_encoder_loader : encodes field tuples and streams them into imem
// Revision: 1.0
// ---------------------------------------------------------------------------
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int AW   = 8,
  parameter int BASE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW:0]     count,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      kind,
  input  logic [4:0]      rs,
  input  logic [4:0]      rt,
  input  logic [4:0]      rd,
  input  logic [5:0]      func,
  input  logic [15:0]     imm,
  input  logic [25:0]     target,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [WORD-1:0] imem_wdata,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e          state;
  logic [AW:0]     remaining;
  logic [AW-1:0]   addr_cnt;
  logic [WORD-1:0] word;
  logic            illegal;
  logic            xfer;

  inst_pack u_pack (
    .kind    (kind),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .func    (func),
    .imm     (imm),
    .target  (target),
    .word    (word),
    .illegal (illegal)
  );

  assign in_ready = (state == S_LOAD) && (remaining != '0);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      remaining  <= '0;
      addr_cnt   <= AW'(BASE);
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err      <= 1'b0;
            addr_cnt <= AW'(BASE);
            if (count != '0) begin
              remaining <= count;
              cpu_hold  <= 1'b1;
              busy      <= 1'b1;
              state     <= S_LOAD;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            imem_we    <= 1'b1;
            imem_addr  <= addr_cnt;
            imem_wdata <= word;
            addr_cnt   <= addr_cnt + 1'b1;
            remaining  <= remaining - 1'b1;
            if (illegal) err <= 1'b1;
            if (remaining == (AW+1)'(1)) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // the last word is on the write port this cycle
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          cpu_hold <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_inst_encoder_loader : scoreboard bench for the encoder/loader
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2, in_valid, in_valid2;
  logic [8:0]  count;
  logic [2:0]  count2;
  logic [2:0]  kind;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  func;
  logic [15:0] imm;
  logic [25:0] target;

  logic        in_ready, imem_we, cpu_hold, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        in_ready2, imem_we2, cpu_hold2, busy2, done2, err2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int first_xfer, last_xfer;
  logic [7:0] exp_addr;
  logic [1:0] exp_addr2;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  inst_encoder_loader #(.AW(8), .BASE(0)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .in_valid(in_valid),
    .in_ready(in_ready), .kind(kind), .rs(rs), .rt(rt), .rd(rd), .func(func),
    .imm(imm), .target(target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  inst_encoder_loader #(.AW(2), .BASE(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .count(count2), .in_valid(in_valid2),
    .in_ready(in_ready2), .kind(kind), .rs(rs), .rt(rt), .rd(rd), .func(func),
    .imm(imm), .target(target), .imem_we(imem_we2), .imem_addr(imem_addr2),
    .imem_wdata(imem_wdata2), .cpu_hold(cpu_hold2), .busy(busy2), .done(done2), .err(err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitors: pop and compare whenever a write appears
  always @(negedge clk) begin : mon1
    exp_t e;
    if (imem_we === 1'b1) begin
      if (q1.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("imem_addr", {24'b0, imem_addr}, {24'b0, e.addr});
        chk("imem_wdata", imem_wdata, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (imem_we2 === 1'b1) begin
      if (q2.size() == 0) chk("unexpected_write2", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("imem_addr2", {24'b0, imem_addr2}, {24'b0, e.addr});
        chk("imem_wdata2", imem_wdata2, e.data);
      end
    end
  end

  task automatic set_fields(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                            input logic [4:0] d, input logic [5:0] f, input logic [15:0] im,
                            input logic [25:0] tg);
    kind = k; rs = s; rt = t; rd = d; func = f; imm = im; target = tg;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [5:0] f, input logic [15:0] im,
                      input logic [25:0] tg, input logic [31:0] expw);
    int n = 0;
    @(negedge clk);
    set_fields(k, s, t, d, f, im, tg);
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    q1.push_back('{exp_addr, expw});
    exp_addr++;
    last_xfer = cyc;
    @(posedge clk);
  endtask

  task automatic send2(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                       input logic [15:0] im, input logic [31:0] expw);
    int n = 0;
    @(negedge clk);
    set_fields(k, s, t, 5'd0, 6'd0, im, 26'd0);
    in_valid2 = 1'b1;
    while (!in_ready2 && n < 20) begin @(negedge clk); n++; end
    if (!in_ready2) begin
      chk("in_ready2_timeout", 32'd0, 32'd1);
      in_valid2 = 1'b0;
      return;
    end
    q2.push_back('{{6'd0, exp_addr2}, expw});
    exp_addr2++;
    @(posedge clk);
  endtask

  task automatic do_start(input logic [8:0] c);
    @(negedge clk);
    count = c;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    exp_addr = 8'd0;
  endtask

  task automatic wait_done(input logic exp_err);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("busy_in_done", {31'b0, busy}, 32'd0);
    chk("hold_in_done", {31'b0, cpu_hold}, 32'd1);
    chk("err_at_done", {31'b0, err}, {31'b0, exp_err});
    @(negedge clk);
    chk("done_pulse_end", {31'b0, done}, 32'd0);
    chk("hold_dropped", {31'b0, cpu_hold}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    count = '0; count2 = '0; exp_addr = 8'd0; exp_addr2 = 2'd3;
    set_fields(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    @(negedge clk);
    chk("rst_outputs", {26'b0, imem_we, in_ready, cpu_hold, busy, done, err}, 32'd0);
    chk("rst_addr_data", imem_wdata | {24'b0, imem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single addi, exact done/hold timing
    do_start(9'd1);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_hold", {31'b0, cpu_hold}, 32'd1);
    send(3'd3, 5'd0, 5'd1, 5'd0, 6'd0, 16'd5, 26'd0, 32'h20010005);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_flush_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_done", {29'b0, done, busy, cpu_hold}, 32'b101);
    @(negedge clk);
    chk("t1_idle", {29'b0, done, busy, cpu_hold}, 32'b000);

    // six back-to-back tuples with in_valid held high
    do_start(9'd6);
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 26'd0, 32'h00221820);
    first_xfer = last_xfer;
    send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'd4, 26'd0, 32'h8C220004);
    send(3'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'd8, 26'd0, 32'hAC220008);
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 32'h1022FFFF);
    send(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 32'h08000010);
    send(3'd7, 5'd9, 5'd9, 5'd9, 6'h3F, 16'h1234, 26'h3FFFFFF, 32'h00000000);
    chk("t2_consecutive", last_xfer - first_xfer, 32'd5);
    @(negedge clk);
    chk("t2_ready_low", {31'b0, in_ready}, 32'd0);
    chk("t2_err", {31'b0, err}, 32'd1);
    wait_done(1'b1);

    // count=0: done pulse, no writes, no busy, err cleared
    do_start(9'd0);
    chk("t3_done", {29'b0, done, busy, err}, 32'b100);
    @(negedge clk);
    chk("t3_after", {29'b0, done, busy, cpu_hold}, 32'b000);

    // start during LOAD is ignored
    do_start(9'd3);
    send(3'd3, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0007, 26'd0, 32'h20430007);
    @(negedge clk);
    in_valid = 1'b0;
    count = 9'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_still_load", {30'b0, busy, in_ready}, 32'b11);
    send(3'd2, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0010, 26'd0, 32'h14850010);
    send(3'd0, 5'd6, 5'd7, 5'd8, 6'h22, 16'd0, 26'd0, 32'h00C74022);
    wait_done(1'b0);

    // reset mid-load after 2 of 4 words
    do_start(9'd4);
    send(3'd3, 5'd0, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0, 32'h20010001);
    send(3'd3, 5'd0, 5'd1, 5'd0, 6'd0, 16'd2, 26'd0, 32'h20010002);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk("t5_rst_abort", {28'b0, imem_we, cpu_hold, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_start(9'd1);
    send(3'd3, 5'd0, 5'd1, 5'd0, 6'd0, 16'd3, 26'd0, 32'h20010003);
    wait_done(1'b0);

    // AW=2, BASE=3: address wraps 3 -> 0 -> 1
    @(negedge clk);
    count2 = 3'd3;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    exp_addr2 = 2'd3;
    send2(3'd3, 5'd0, 5'd1, 16'd10, 32'h2001000A);
    send2(3'd3, 5'd0, 5'd2, 16'd11, 32'h2002000B);
    send2(3'd3, 5'd0, 5'd3, 16'd12, 32'h2003000C);
    begin
      int n = 0;
      @(negedge clk);
      in_valid2 = 1'b0;
      while (!done2 && n < 20) begin @(negedge clk); n++; end
      chk("t6_done2", {31'b0, done2}, 32'd1);
    end

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
